// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority with a bounded-wait guarantee for the DMA port.
// Define DMEM_ARB_LOCK_EN to add dma_lock, which lets DMA hold the port exclusively.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        dma_lock,
`endif
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
  logic              force_c, locked_c, cpu_gnt_c, dma_gnt_c;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {OWN_NONE, OWN_DMA} owner_e;
  owner_e owner_q, owner_d;

  // Ownership lapses in the same cycle dma_lock drops, so the CPU can win that cycle.
  assign locked_c = (owner_q == OWN_DMA) && dma_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  always_comb begin
    owner_d = owner_q;
    if (dma_gnt_c && dma_lock) owner_d = OWN_DMA;
    else if (!dma_lock)        owner_d = OWN_NONE;
  end
`else
  assign locked_c = 1'b0;
`endif

  // Combinational arbitration; grants are gated by reset so nothing leaks while it is low.
  always_comb begin
    force_c   = dma_req && (wait_cnt_q >= MAX_WAIT_C);
    dma_gnt_c = reset && dma_req && (force_c || !cpu_req || locked_c);
    cpu_gnt_c = reset && cpu_req && !dma_gnt_c && !locked_c;
  end

  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rvalid_d = cpu_gnt_c && (cpu_byteen == 4'b0000);
    dma_rvalid_d = dma_gnt_c && (dma_byteen == 4'b0000);
    cpu_rdata_d  = cpu_rvalid_d ? m_data_rdata : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? m_data_rdata : dma_rdata_q;
    wait_cnt_d   = '0;
    if (cpu_gnt_c) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end else if (dma_gnt_c) begin
      addr_d  = dma_addr;
      wdata_d = dma_wdata;
    end
    if (dma_req && !dma_gnt_c && !locked_c)
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // Idle cycles replay the last address/data but never write.
  always_comb begin
    cpu_gnt       = cpu_gnt_c;
    dma_gnt       = dma_gnt_c;
    cpu_rvalid    = cpu_rvalid_q;
    dma_rvalid    = dma_rvalid_q;
    cpu_rdata     = cpu_rdata_q;
    dma_rdata     = dma_rdata_q;
    m_data_addr   = addr_q;
    m_data_wdata  = wdata_q;
    m_data_byteen = 4'b0000;
    if (cpu_gnt_c) begin
      m_data_addr   = cpu_addr;
      m_data_wdata  = cpu_wdata;
      m_data_byteen = cpu_byteen;
    end else if (dma_gnt_c) begin
      m_data_addr   = dma_addr;
      m_data_wdata  = dma_wdata;
      m_data_byteen = dma_byteen;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a shadow-memory
// model; read data is checked by a separate monitor draining per-port expectation queues.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 8;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        act;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, dma_req = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [3:0]  cpu_byteen = '0, dma_byteen = '0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata, m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
`ifdef DMEM_ARB_LOCK_EN
  logic        dma_lock = 1'b0;
`endif

  logic [31:0] mem    [0:63] = '{default: 32'h0};
  logic [31:0] shadow [0:63] = '{default: 32'h0};
  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          streak = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_byteen(dma_byteen),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .dma_lock(dma_lock),
`endif
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the port: combinational read, byte-lane writes at the clock edge.
  assign m_data_rdata = mem[m_data_addr[7:2]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (m_data_byteen[b]) mem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cpu_q.delete();
    dma_q.delete();
    streak     = 0;
    last_addr  = '0;
    last_wdata = '0;
  endtask

  // One bus cycle: drive, compare grant/memory-port against the model, queue read data.
  task automatic cycle(input logic creq, input logic [31:0] ca, input logic [31:0] cw,
                       input logic [3:0] cb, input logic dreq, input logic [31:0] da,
                       input logic [31:0] dw, input logic [3:0] db,
                       output logic cg, output logic dg);
    logic        eg_c, eg_d;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    exp_t        e;
    cpu_req = creq; cpu_addr = ca; cpu_wdata = cw; cpu_byteen = cb;
    dma_req = dreq; dma_addr = da; dma_wdata = dw; dma_byteen = db;
    #1;
    eg_d = dreq && (streak >= MAX_WAIT || !creq);
    eg_c = creq && !eg_d;
    cg = cpu_gnt;
    dg = dma_gnt;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    if (eg_c)      begin ea = ca; ew = cw; eb = cb; end
    else if (eg_d) begin ea = da; ew = dw; eb = db; end
    else           begin ea = last_addr; ew = last_wdata; eb = 4'b0000; end
    chk("m_data_addr", m_data_addr, ea);
    chk("m_data_wdata", m_data_wdata, ew);
    chk("m_data_byteen", 32'(m_data_byteen), 32'(eb));
    if (eg_c || eg_d) begin
      last_addr  = ea;
      last_wdata = ew;
      if (eb == 4'b0000) begin
        e.due  = cyc + 1;
        e.data = shadow[ea[7:2]];
        if (eg_c) cpu_q.push_back(e);
        else      dma_q.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (eb[b]) shadow[ea[7:2]][8*b +: 8] = ew[8*b +: 8];
      end
    end
    if (dreq && !eg_d) streak = (streak < 255) ? streak + 1 : 255;
    else               streak = 0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle, rvalid must match the queue head's due cycle, then data is compared.
  initial begin
    exp_t e;
    logic ev;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        ev = (cpu_q.size() != 0) && (cpu_q[0].due == cyc);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev));
        if (ev) begin
          e = cpu_q.pop_front();
          if (cpu_rvalid) chk("cpu_rdata", cpu_rdata, e.data);
        end
        ev = (dma_q.size() != 0) && (dma_q[0].due == cyc);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(ev));
        if (ev) begin
          e = dma_q.pop_front();
          if (dma_rvalid) chk("dma_rdata", dma_rdata, e.data);
        end
      end
    end
  end

  initial begin
    logic cg, dg;
    int   n;
    req_t cp, dp;

    @(posedge clk); #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_byteen", 32'(m_data_byteen), 32'd0);
    chk("rst_addr", m_data_addr, 32'd0);
    chk("rst_wdata", m_data_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // CPU-only full-word write then read back
    cycle(1, 32'h10, 32'h12345678, 4'hF, 0, 0, 0, 4'h0, cg, dg);
    cycle(1, 32'h10, 32'h0, 4'h0, 0, 0, 0, 4'h0, cg, dg);
    chk("cpu_read_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("cpu_read_data", cpu_rdata, 32'h12345678);
    chk("cpu_read_dma_rvalid", 32'(dma_rvalid), 32'd0);
    cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, cg, dg);
    chk("cpu_rvalid_one_cycle", 32'(cpu_rvalid), 32'd0);

    // Single-lane write merges into the existing word
    cycle(1, 32'h10, 32'h0000AB00, 4'b0010, 0, 0, 0, 4'h0, cg, dg);
    cycle(1, 32'h10, 32'h0, 4'h0, 0, 0, 0, 4'h0, cg, dg);
    chk("byte_write_data", cpu_rdata, 32'h1234AB78);

    // Contention: CPU keeps requesting, DMA read is forced through after MAX_WAIT denials
    cycle(0, 0, 0, 4'h0, 1, 32'h20, 32'hDEADBEEF, 4'hF, cg, dg);
    n = -1;
    for (int i = 0; i < 20 && n < 0; i++) begin
      cycle(1, 32'h40, 32'h100 + 32'(i), 4'hF, 1, 32'h20, 32'h0, 4'h0, cg, dg);
      if (dg) n = i;
    end
    chk("dma_forced_at", 32'(n), 32'd8);
    chk("dma_forced_rvalid", 32'(dma_rvalid), 32'd1);
    chk("dma_forced_rdata", dma_rdata, 32'hDEADBEEF);
    chk("dma_forced_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    cycle(1, 32'h40, 32'h200, 4'hF, 1, 32'h24, 32'h55, 4'hF, cg, dg);
    chk("cpu_after_force", 32'(cg), 32'd1);

    // Reset asserted while a CPU write is granted and a read result is on rvalid
    cycle(1, 32'h10, 32'h0, 4'h0, 0, 0, 0, 4'h0, cg, dg);
    cpu_req = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D; cpu_byteen = 4'hF;
    dma_req = 0; dma_byteen = 4'h0;
    #1;
    chk("pre_rst_byteen", 32'(m_data_byteen), 32'hF);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_byteen", 32'(m_data_byteen), 32'd0);
    chk("mid_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("mid_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_addr", m_data_addr, 32'd0);
    @(posedge clk); #1;
    chk("rst_write_suppressed", mem[12], shadow[12]);
    #2;
    cpu_req = 0;
    reset = 1'b1;
    #1;
    chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("post_rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("post_rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(posedge clk); #1;
    cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, cg, dg);

    // Random traffic; each requester holds its payload until granted
    cp.act = 0; cp.a = '0; cp.w = '0; cp.b = '0;
    dp = cp;
    for (int i = 0; i < 1500; i++) begin
      if (!cp.act && $urandom_range(0, 99) < 85) begin
        cp.act = 1;
        cp.a   = {24'h0, 6'($urandom), 2'b00};
        cp.w   = $urandom;
        cp.b   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      end
      if (!dp.act && $urandom_range(0, 99) < 40) begin
        dp.act = 1;
        dp.a   = {24'h0, 6'($urandom), 2'b00};
        dp.w   = $urandom;
        dp.b   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      end
      cycle(cp.act, cp.a, cp.w, cp.b, dp.act, dp.a, dp.w, dp.b, cg, dg);
      if (cg) cp.act = 0;
      if (dg) dp.act = 0;
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, cg, dg);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dma_q_drained", 32'(dma_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], shadow[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
